// File: rtl/sig_ctrl_pkg.sv
// Shared types and constants for the signal-generator front-panel controller.
package sig_ctrl_pkg;
  typedef enum logic {EDIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] SEL_SIG = 2'd0;
  localparam logic [1:0] SEL_AMP = 2'd1;
  localparam logic [1:0] SEL_FRE = 2'd2;
  localparam logic [1:0] SEL_PHA = 2'd3;

  localparam logic [1:0] WAV_SIN = 2'd0;
  localparam logic [1:0] WAV_SQU = 2'd1;
  localparam logic [1:0] WAV_TRI = 2'd2;
  localparam logic [1:0] WAV_SAW = 2'd3;

  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/key_debounce.sv
// One push-button: synchroniser, optional debounce (SIG_CTRL_DEBOUNCE_EN), press pulse.
module key_debounce
  import sig_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   stable;
  logic                   stable_d;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
  end
  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SIG_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the input disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (sync_out == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      stable <= sync_out;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
`else
  // DEB_CYCLES has no effect in this build.
  logic deb_unused;
  assign deb_unused = ^DEB_CYCLES;
  assign stable     = sync_out;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) stable_d <= 1'b1;
    else        stable_d <= stable;
  end

  assign press = stable_d & ~stable;
endmodule

// File: rtl/sig_ctrl.sv
// Front-panel edit/run controller; parameter codes update only on commit.
// Debounce is enabled by defining SIG_CTRL_DEBOUNCE_EN.
module sig_ctrl
  import sig_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_ok_n,
  output logic [1:0] cnt_sig,
  output logic [1:0] cnt_amp,
  output logic [1:0] cnt_fre,
  output logic [1:0] cnt_phase,
  output logic       confirm,
  output logic [1:0] sel,
  output logic       editing
);
  logic mode_ev, inc_ev, ok_ev;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk(clk), .rst_n(rst_n), .key_n(key_mode_n), .press(mode_ev));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
    .clk(clk), .rst_n(rst_n), .key_n(key_inc_n), .press(inc_ev));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ok (
    .clk(clk), .rst_n(rst_n), .key_n(key_ok_n), .press(ok_ev));

  state_t     state, state_nxt;
  logic [1:0] sh_sig, sh_amp, sh_fre, sh_pha;
  logic [1:0] sh_sig_nxt, sh_amp_nxt, sh_fre_nxt, sh_pha_nxt;
  logic [1:0] cnt_sig_nxt, cnt_amp_nxt, cnt_fre_nxt, cnt_phase_nxt;
  logic [1:0] sel_nxt;
  logic       confirm_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EDIT;
      sel       <= SEL_SIG;
      sh_sig    <= WAV_SIN;
      sh_amp    <= 2'd0;
      sh_fre    <= 2'd0;
      sh_pha    <= 2'd0;
      cnt_sig   <= WAV_SIN;
      cnt_amp   <= 2'd0;
      cnt_fre   <= 2'd0;
      cnt_phase <= 2'd0;
      confirm   <= 1'b0;
      editing   <= 1'b1;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      sh_sig    <= sh_sig_nxt;
      sh_amp    <= sh_amp_nxt;
      sh_fre    <= sh_fre_nxt;
      sh_pha    <= sh_pha_nxt;
      cnt_sig   <= cnt_sig_nxt;
      cnt_amp   <= cnt_amp_nxt;
      cnt_fre   <= cnt_fre_nxt;
      cnt_phase <= cnt_phase_nxt;
      confirm   <= confirm_nxt;
      editing   <= (state_nxt == EDIT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EDIT:    if (ok_ev) state_nxt = RUN;
      RUN:     if (ok_ev) state_nxt = EDIT;
      default: state_nxt = EDIT;
    endcase
  end

  // ok outranks mode, mode outranks inc; losers in the same cycle are dropped.
  always_comb begin
    sel_nxt       = sel;
    sh_sig_nxt    = sh_sig;
    sh_amp_nxt    = sh_amp;
    sh_fre_nxt    = sh_fre;
    sh_pha_nxt    = sh_pha;
    cnt_sig_nxt   = cnt_sig;
    cnt_amp_nxt   = cnt_amp;
    cnt_fre_nxt   = cnt_fre;
    cnt_phase_nxt = cnt_phase;
    confirm_nxt   = confirm;
    case (state)
      EDIT: begin
        if (ok_ev) begin
          cnt_sig_nxt   = sh_sig;
          cnt_amp_nxt   = sh_amp;
          cnt_fre_nxt   = sh_fre;
          cnt_phase_nxt = sh_pha;
          confirm_nxt   = 1'b1;
        end else if (mode_ev) begin
          sel_nxt = sel + 2'd1;
        end else if (inc_ev) begin
          case (sel)
            SEL_SIG: sh_sig_nxt = sh_sig + 2'd1;
            SEL_AMP: sh_amp_nxt = sh_amp + 2'd1;
            SEL_FRE: sh_fre_nxt = sh_fre + 2'd1;
            SEL_PHA: sh_pha_nxt = sh_pha + 2'd1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (ok_ev) confirm_nxt = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sig_ctrl.sv
// Scoreboard bench for sig_ctrl: directed key presses, monitor checks every output change.
module tb_sig_ctrl;
  localparam int DEB = 4;
`ifdef SIG_CTRL_DEBOUNCE_EN
  localparam int LAT  = DEB + 3;
  localparam int HOLD = DEB + 2;
  localparam int LONG = 10;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 1;
  localparam int LONG = 1;
`endif
  localparam int GAP = DEB + 6;
  localparam logic [2:0] K_MODE = 3'b001;
  localparam logic [2:0] K_INC  = 3'b010;
  localparam logic [2:0] K_OK   = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_mode_n = 1'b1, key_inc_n = 1'b1, key_ok_n = 1'b1;
  logic [1:0] cnt_sig, cnt_amp, cnt_fre, cnt_phase, sel;
  logic confirm, editing;

  sig_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_ok_n(key_ok_n),
    .cnt_sig(cnt_sig), .cnt_amp(cnt_amp), .cnt_fre(cnt_fre), .cnt_phase(cnt_phase),
    .confirm(confirm), .sel(sel), .editing(editing));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] val;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  logic [11:0] outv;
  assign outv = {cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, sel, editing};

  function automatic logic [11:0] pk(input logic [1:0] s, input logic [1:0] a,
                                     input logic [1:0] f, input logic [1:0] p,
                                     input logic c, input logic [1:0] sl, input logic e);
    return {s, a, f, p, c, sl, e};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  logic [11:0] prev;
  sb_t         ent;
  always @(negedge clk) begin
    if (mon_en && outv !== prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_change: got 0x%0h at cycle %0d, required no change (was 0x%0h)",
                 outv, cyc, prev);
      end else begin
        ent = sb_q.pop_front();
        n_cmp += 2;
        if (outv !== ent.val) begin
          n_bad++;
          $display("FAIL out_value: got 0x%0h, required 0x%0h (cycle %0d)", outv, ent.val, cyc);
        end
        if (cyc != ent.cyc) begin
          n_bad++;
          $display("FAIL out_latency: change at cycle %0d, required cycle %0d", cyc, ent.cyc);
        end
      end
    end
    prev = outv;
  end

  task automatic set_keys(input logic [2:0] mask, input logic lvl);
    if (mask[0]) key_mode_n = lvl;
    if (mask[1]) key_inc_n  = lvl;
    if (mask[2]) key_ok_n   = lvl;
  endtask

  // Press starts after the edge at cycle t0; any visible change is due at edge t0+LAT.
  task automatic press(input logic [2:0] mask, input int hold, input bit change,
                       input logic [11:0] expv);
    int t0;
    @(negedge clk);
    t0 = cyc;
    set_keys(mask, 1'b0);
    if (change) sb_q.push_back('{val: expv, cyc: t0 + LAT});
    repeat (hold) @(negedge clk);
    set_keys(mask, 1'b1);
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check("reset_state", outv, pk(0, 0, 0, 0, 0, 0, 1));
    rst_n  = 1'b1;
    prev   = outv;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

`ifdef SIG_CTRL_DEBOUNCE_EN
    press(K_INC, 3, 1'b0, '0);
    check("glitch_no_inc", dut.sh_sig, 0);
`endif

    // Long inc press: shadow sig must flip exactly at edge t0+LAT.
    @(negedge clk);
    t0 = cyc;
    key_inc_n = 1'b0;
    for (int i = 1; i <= LONG + GAP; i++) begin
      @(negedge clk);
      if (i == LONG) key_inc_n = 1'b1;
      if (i == LAT - 1) check("sh_sig_before", dut.sh_sig, 0);
      if (i == LAT)     check("sh_sig_at_edge", dut.sh_sig, 1);
    end
    if (cyc != t0 + LONG + GAP) check("long_press_cycles", cyc, t0 + LONG + GAP);

    // Edit sequence, then commit.
    press(K_INC, HOLD, 1'b0, '0);
    press(K_INC, HOLD, 1'b0, '0);
    press(K_MODE, HOLD, 1'b1, pk(0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 5; i++) press(K_INC, HOLD, 1'b0, '0);
    press(K_MODE, HOLD, 1'b1, pk(0, 0, 0, 0, 0, 2, 1));
    press(K_MODE, HOLD, 1'b1, pk(0, 0, 0, 0, 0, 3, 1));
    press(K_INC, HOLD, 1'b0, '0);
    press(K_INC, HOLD, 1'b0, '0);
    press(K_OK, HOLD, 1'b1, pk(3, 1, 0, 2, 1, 3, 0));

    // RUN lockout.
    press(K_INC, HOLD, 1'b0, '0);
    press(K_MODE, HOLD, 1'b0, '0);
    press(K_OK, HOLD, 1'b1, pk(3, 1, 0, 2, 0, 3, 1));

    // ok beats inc.
    press(K_OK | K_INC, HOLD, 1'b1, pk(3, 1, 0, 2, 1, 3, 0));
    check("prio_ok_inc_sh_pha", dut.sh_pha, 2);
    press(K_OK, HOLD, 1'b1, pk(3, 1, 0, 2, 0, 3, 1));
    // mode beats inc, sel wraps 3->0.
    press(K_MODE | K_INC, HOLD, 1'b1, pk(3, 1, 0, 2, 0, 0, 1));
    press(K_OK, HOLD, 1'b1, pk(3, 1, 0, 2, 1, 0, 0));
    press(K_OK, HOLD, 1'b1, pk(3, 1, 0, 2, 0, 0, 1));
    // sig wraps 3->0.
    press(K_INC, HOLD, 1'b0, '0);
    press(K_OK, HOLD, 1'b1, pk(0, 1, 0, 2, 1, 0, 0));

    // Reset while in RUN, with mode held low through reset.
    @(negedge clk);
    rst_n = 1'b0;
    key_mode_n = 1'b0;
    sb_q.push_back('{val: pk(0, 0, 0, 0, 0, 0, 1), cyc: cyc + 1});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back('{val: pk(0, 0, 0, 0, 0, 1, 1), cyc: cyc + LAT});
    repeat (LAT + 3) @(negedge clk);
    key_mode_n = 1'b1;
    repeat (GAP + 10) @(negedge clk);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
